bmem_line_ctrl: RTL and testbench

Line-to-burst controller between the cache arbiter and the burst memory model. Accepts one 256-bit line request at a time from the arbiter (read fill or dirty writeback). Sequences it as a 4-beat, 64-bit burst transaction on the memory side. Returns the assembled line or a write-done pulse to the arbiter. Single outstanding transaction; the arbiter holds requests until `arb_ready` is high.

---
 rtl/bmem_line_ctrl_pkg.sv | 17 +
 rtl/bmem_line_ctrl_if.sv | 32 +++
 rtl/bmem_line_ctrl_line_beat_buf.sv | 40 ++++
 rtl/bmem_line_ctrl.sv | 144 ++++++++++++++
 tb/tb_bmem_line_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmem_line_ctrl_pkg.sv
// Shared types and constants for the line-to-burst memory controller.
package bmem_ctrl_pkg;

  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = 2;
  localparam int LINE_OFS_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WR_RESP,
    RD_REQ,
    RD_BEAT,
    RD_RESP
  } bmem_state_t;

endpackage

// File: rtl/bmem_line_ctrl_if.sv
// Arbiter-side line bus and memory-side burst bus for bmem_line_ctrl.
interface bmem_arb_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic [ADDR_W-1:0] arb_addr;
  logic              arb_read;
  logic              arb_write;
  logic [LINE_W-1:0] arb_wdata;
  logic              arb_ready;
  logic [LINE_W-1:0] arb_rdata;
  logic              arb_rvalid;
  logic              arb_wdone;

  modport master (output arb_addr, arb_read, arb_write, arb_wdata,
                  input  arb_ready, arb_rdata, arb_rvalid, arb_wdone);
  modport slave  (input  arb_addr, arb_read, arb_write, arb_wdata,
                  output arb_ready, arb_rdata, arb_rvalid, arb_wdone);
endinterface

interface bmem_mem_if #(parameter int ADDR_W = 32, parameter int BEAT_W = 64);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_raddr;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (output mem_addr, mem_read, mem_write, mem_wdata,
                  input  mem_ready, mem_raddr, mem_rdata, mem_rvalid);
  modport slave  (input  mem_addr, mem_read, mem_write, mem_wdata,
                  output mem_ready, mem_raddr, mem_rdata, mem_rvalid);
endinterface

// File: rtl/bmem_line_ctrl_line_beat_buf.sv
// Line buffer: whole-line load for writebacks, beat-indexed fill for reads.
module line_beat_buf
  import bmem_ctrl_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LINE_W-1:0]     load_line,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_idx,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic [BEAT_IDX_W-1:0] rd_idx,
  output logic [BEAT_W-1:0]     rd_beat,
  output logic [LINE_W-1:0]     line_merged
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[int'(wr_idx)*BEAT_W +: BEAT_W] <= wr_beat;
    end
  end

  assign rd_beat = line_q[int'(rd_idx)*BEAT_W +: BEAT_W];

  // Line as it will look once the incoming beat lands; lets the last beat go straight out.
  always_comb begin
    line_merged = line_q;
    line_merged[int'(wr_idx)*BEAT_W +: BEAT_W] = wr_beat;
  end

endmodule

// File: rtl/bmem_line_ctrl.sv
// Turns one 256-bit line request into a 4-beat 64-bit memory burst.
// Optional BMEM_RADDR_CHECK_EN: flags read-address mismatches and stray read beats on err.
module bmem_line_ctrl
  import bmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  bmem_arb_if.slave  arb,
  bmem_mem_if.master mem,
  output logic       err
);

  bmem_state_t                    state;
  logic [BEAT_IDX_W-1:0]          cnt;
  logic [ADDR_W-LINE_OFS_W-1:0]   addr_q;
  logic                           mem_read_q;
  logic                           mem_write_q;
  logic                           rvalid_q;
  logic                           wdone_q;
  logic [LINE_W-1:0]              rdata_q;
  logic                           buf_load;
  logic                           buf_wr_en;
  logic [BEAT_W-1:0]              beat_out;
  logic [LINE_W-1:0]              line_merged;
  logic                           last_beat;

  assign buf_load  = (state == IDLE) && arb.arb_write;
  assign buf_wr_en = (state == RD_BEAT) && mem.mem_rvalid;
  assign last_beat = (cnt == BEAT_IDX_W'(BEATS - 1));

  line_beat_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (buf_load),
    .load_line   (arb.arb_wdata),
    .wr_en       (buf_wr_en),
    .wr_idx      (cnt),
    .wr_beat     (mem.mem_rdata),
    .rd_idx      (cnt),
    .rd_beat     (beat_out),
    .line_merged (line_merged)
  );

  // Write wins over read in IDLE; the arbiter re-presents a dropped read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rvalid_q    <= 1'b0;
      wdone_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb.arb_write) begin
            addr_q      <= arb.arb_addr[ADDR_W-1:LINE_OFS_W];
            mem_write_q <= 1'b1;
            state       <= WR_BEAT;
          end else if (arb.arb_read) begin
            addr_q     <= arb.arb_addr[ADDR_W-1:LINE_OFS_W];
            mem_read_q <= 1'b1;
            state      <= RD_REQ;
          end
        end
        WR_BEAT: begin
          if (mem.mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              mem_write_q <= 1'b0;
              wdone_q     <= 1'b1;
              state       <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        RD_REQ: begin
          if (mem.mem_ready) begin
            mem_read_q <= 1'b0;
            state      <= RD_BEAT;
          end
        end
        RD_BEAT: begin
          if (mem.mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              rdata_q  <= line_merged;
              rvalid_q <= 1'b1;
              state    <= RD_RESP;
            end
          end
        end
        RD_RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign arb.arb_ready  = (state == IDLE);
  assign arb.arb_rdata  = rdata_q;
  assign arb.arb_rvalid = rvalid_q;
  assign arb.arb_wdone  = wdone_q;

  assign mem.mem_addr  = {addr_q, {LINE_OFS_W{1'b0}}};
  assign mem.mem_read  = mem_read_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_wdata = mem_write_q ? beat_out : '0;

  logic unused_ofs;
  assign unused_ofs = ^arb.arb_addr[LINE_OFS_W-1:0];

`ifdef BMEM_RADDR_CHECK_EN
  // Sticky: data is still stored and the burst completes even after a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mem.mem_rvalid &&
                 ((state != RD_BEAT) ||
                  (mem.mem_raddr != {addr_q, {LINE_OFS_W{1'b0}}}))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^mem.mem_raddr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_line_ctrl.sv
// Random and directed bench for bmem_line_ctrl against a transaction-level model.
module tb_bmem_line_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int   n_checks = 0;
  int   n_errors = 0;

  bmem_arb_if arb_if ();
  bmem_mem_if mem_if ();

  bmem_line_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if),
    .mem   (mem_if),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder knobs, changed by the main sequence only at negedges.
  int   ready_pct = 100;
  int   fixed_gap = 0;
  int   corrupt_idx = -1;
  bit   rand_data = 1'b0;
  bit   allow_spurious = 1'b0;
  int   pending = 0;
  int   idle_ctr = 0;
  bit   sent_real = 1'b0;
  bit   acc_cmd = 1'b0;
  bit   beat_taken = 1'b0;
  logic [31:0] cmd_addr = '0;

  always @(negedge clk) begin
    acc_cmd    = mem_if.mem_read && mem_if.mem_ready;
    if (acc_cmd) cmd_addr = mem_if.mem_addr;
    beat_taken = mem_if.mem_rvalid && sent_real;
  end

  initial begin
    mem_if.mem_ready  = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    mem_if.mem_raddr  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (beat_taken) pending--;
        if (acc_cmd) begin
          pending  = 4;
          idle_ctr = fixed_gap;
        end
      end
      mem_if.mem_ready  = ($urandom_range(0, 99) < ready_pct);
      mem_if.mem_rvalid = 1'b0;
      sent_real = 1'b0;
      if (rst_n && pending > 0) begin
        bit send;
        int idx;
        send = (fixed_gap < 0) ? ($urandom_range(0, 99) < 60) : (idle_ctr >= fixed_gap);
        if (send) begin
          idx = 4 - pending;
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = rand_data ? {$urandom, $urandom} : 64'h0123456789abcd00 + 64'(idx);
          mem_if.mem_raddr  = cmd_addr + ((idx == corrupt_idx) ? 32'h20 : 32'h0);
          sent_real = 1'b1;
          idle_ctr  = 0;
        end else begin
          idle_ctr++;
        end
      end else if (allow_spurious && $urandom_range(0, 99) < 5) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = {$urandom, $urandom};
        mem_if.mem_raddr  = $urandom;
      end
    end
  end

  // Transaction-level model: queues of outstanding beats and received beats.
  bit          m_busy = 1'b0;
  logic [63:0] m_wq[$];
  logic [63:0] m_rd_got[$];
  bit          m_rd_cmd = 1'b0;
  bit          m_rd_active = 1'b0;
  bit          m_wdone = 1'b0;
  bit          m_rvalid = 1'b0;
  bit          m_err = 1'b0;
  logic [255:0] m_rline = '0;
  logic [31:0]  m_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_wq.delete();
      m_rd_got.delete();
      m_rd_cmd = 1'b0;
      m_rd_active = 1'b0;
      m_wdone = 1'b0;
      m_rvalid = 1'b0;
      m_err = 1'b0;
      m_rline = '0;
      m_addr = '0;
    end else begin
`ifdef BMEM_RADDR_CHECK_EN
      if (mem_if.mem_rvalid && !m_rd_active) m_err = 1'b1;
      if (mem_if.mem_rvalid && m_rd_active && mem_if.mem_raddr != m_addr) m_err = 1'b1;
`endif
      if (m_wdone || m_rvalid) begin
        m_wdone  = 1'b0;
        m_rvalid = 1'b0;
        m_busy   = 1'b0;
      end else if (!m_busy) begin
        if (arb_if.arb_write) begin
          m_busy = 1'b1;
          m_addr = arb_if.arb_addr & 32'hffff_ffe0;
          for (int i = 0; i < 4; i++) m_wq.push_back(arb_if.arb_wdata[64*i +: 64]);
        end else if (arb_if.arb_read) begin
          m_busy   = 1'b1;
          m_addr   = arb_if.arb_addr & 32'hffff_ffe0;
          m_rd_cmd = 1'b1;
          m_rd_got.delete();
        end
      end else if (m_wq.size() != 0) begin
        if (mem_if.mem_ready) begin
          void'(m_wq.pop_front());
          if (m_wq.size() == 0) m_wdone = 1'b1;
        end
      end else if (m_rd_cmd) begin
        if (mem_if.mem_ready) begin
          m_rd_cmd    = 1'b0;
          m_rd_active = 1'b1;
        end
      end else if (m_rd_active) begin
        if (mem_if.mem_rvalid) begin
          m_rd_got.push_back(mem_if.mem_rdata);
          if (m_rd_got.size() == 4) begin
            m_rline     = {m_rd_got[3], m_rd_got[2], m_rd_got[1], m_rd_got[0]};
            m_rd_active = 1'b0;
            m_rvalid    = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("arb_ready", arb_if.arb_ready, !m_busy);
    check_output("mem_write", mem_if.mem_write, m_wq.size() != 0);
    if (m_wq.size() != 0) begin
      check_output("mem_wdata", mem_if.mem_wdata, m_wq[0]);
      check_output("wr_addr", mem_if.mem_addr, m_addr);
    end
    check_output("mem_read", mem_if.mem_read, m_rd_cmd);
    if (m_rd_cmd) check_output("rd_addr", mem_if.mem_addr, m_addr);
    check_output("arb_wdone", arb_if.arb_wdone, m_wdone);
    check_output("arb_rvalid", arb_if.arb_rvalid, m_rvalid);
    check_output("arb_rdata", arb_if.arb_rdata, m_rline);
    check_output("err", err, m_err);
  end

  task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [255:0] wd);
    @(posedge clk);
    #1;
    arb_if.arb_read  = rd;
    arb_if.arb_write = wr;
    arb_if.arb_addr  = addr;
    arb_if.arb_wdata = wd;
    @(posedge clk);
    #1;
    arb_if.arb_read  = 1'b0;
    arb_if.arb_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [63:0]  wexp [4] = '{64'hd0d0d0d000000000, 64'hd1d1d1d100000001,
                             64'hd2d2d2d200000002, 64'hd3d3d3d300000003};
  logic [255:0] wline;
  logic [255:0] rline_exp = 256'h0123456789abcd03_0123456789abcd02_0123456789abcd01_0123456789abcd00;

  initial begin
    int rd_cnt;
    int rv_cnt;
    int wd_cnt;
    int rv_cyc;
    wline = {wexp[3], wexp[2], wexp[1], wexp[0]};
    arb_if.arb_read  = 1'b0;
    arb_if.arb_write = 1'b0;
    arb_if.arb_addr  = '0;
    arb_if.arb_wdata = '0;

    repeat (3) @(negedge clk);
    check_output("rst_ready", arb_if.arb_ready, 1'b1);
    check_output("rst_mem_addr", mem_if.mem_addr, 32'h0);
    check_output("rst_rdata", arb_if.arb_rdata, 256'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write burst, memory always ready.
    @(negedge clk);
    ready_pct = 100;
    apply_stimulus(1'b0, 1'b1, 32'h1eceb01c, wline);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_output("t1_write", mem_if.mem_write, 1'b1);
      check_output("t1_addr", mem_if.mem_addr, 32'h1eceb000);
      check_output("t1_wdata", mem_if.mem_wdata, wexp[k-1]);
    end
    @(negedge clk);
    check_output("t1_wdone", arb_if.arb_wdone, 1'b1);
    @(negedge clk);
    check_output("t1_ready", arb_if.arb_ready, 1'b1);
    check_output("t1_wdone_end", arb_if.arb_wdone, 1'b0);

    // Read with two idle cycles between beats.
    @(negedge clk);
    fixed_gap = 2;
    rand_data = 1'b0;
    apply_stimulus(1'b1, 1'b0, 32'h00000040, '0);
    rd_cnt = 0; rv_cnt = 0; rv_cyc = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (mem_if.mem_read) begin
        rd_cnt++;
        check_output("t2_addr", mem_if.mem_addr, 32'h40);
      end
      if (arb_if.arb_rvalid) begin
        rv_cnt++;
        rv_cyc = cyc;
        check_output("t2_rdata", arb_if.arb_rdata, rline_exp);
      end
    end
    check_output("t2_mem_read_cnt", rd_cnt, 1);
    check_output("t2_rvalid_cnt", rv_cnt, 1);
    check_output("t2_rvalid_cycle", rv_cyc, 12);

    // Backpressure during beat 2.
    @(negedge clk);
    fixed_gap = 0;
    apply_stimulus(1'b0, 1'b1, 32'h00001234, wline);
    @(negedge clk);
    check_output("t3_addr", mem_if.mem_addr, 32'h00001220);
    check_output("t3_w0", mem_if.mem_wdata, wexp[0]);
    @(negedge clk);
    check_output("t3_w1", mem_if.mem_wdata, wexp[1]);
    ready_pct = 0;
    for (int cyc = 3; cyc <= 6; cyc++) begin
      @(negedge clk);
      check_output("t3_w2_hold", mem_if.mem_wdata, wexp[2]);
      check_output("t3_no_wdone", arb_if.arb_wdone, 1'b0);
      if (cyc == 5) ready_pct = 100;
    end
    @(negedge clk);
    check_output("t3_w3", mem_if.mem_wdata, wexp[3]);
    check_output("t3_wdone_early", arb_if.arb_wdone, 1'b0);
    @(negedge clk);
    check_output("t3_wdone", arb_if.arb_wdone, 1'b1);

    // Simultaneous read and write: write only, then the read is served.
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 32'h00000100, ~wline);
    rd_cnt = 0; wd_cnt = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (mem_if.mem_read) rd_cnt++;
      if (arb_if.arb_wdone) wd_cnt++;
    end
    check_output("t4_no_read", rd_cnt, 0);
    check_output("t4_wdone_cnt", wd_cnt, 1);
    apply_stimulus(1'b1, 1'b0, 32'h00000080, '0);
    @(negedge clk);
    check_output("t4_read_cmd", mem_if.mem_read, 1'b1);
    check_output("t4_read_addr", mem_if.mem_addr, 32'h80);
    rv_cnt = 0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (arb_if.arb_rvalid) begin
        rv_cnt++;
        check_output("t4_rdata", arb_if.arb_rdata, rline_exp);
      end
    end
    check_output("t4_rvalid_cnt", rv_cnt, 1);

    // Reset after beat 1 of a read.
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h00000040, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_ready", arb_if.arb_ready, 1'b1);
    check_output("t5_mem_read", mem_if.mem_read, 1'b0);
    check_output("t5_mem_write", mem_if.mem_write, 1'b0);
    check_output("t5_rvalid", arb_if.arb_rvalid, 1'b0);
    check_output("t5_rdata", arb_if.arb_rdata, 256'h0);
    check_output("t5_mem_addr", mem_if.mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rv_cnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (arb_if.arb_rvalid || mem_if.mem_read) rv_cnt++;
    end
    check_output("t5_quiet", rv_cnt, 0);
    apply_stimulus(1'b1, 1'b0, 32'h00000040, '0);
    rv_cnt = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (arb_if.arb_rvalid) begin
        rv_cnt++;
        check_output("t5_rdata_after", arb_if.arb_rdata, rline_exp);
      end
    end
    check_output("t5_rvalid_cnt", rv_cnt, 1);

`ifdef BMEM_RADDR_CHECK_EN
    // Beat 2 tagged with the wrong line address.
    @(negedge clk);
    corrupt_idx = 2;
    apply_stimulus(1'b1, 1'b0, 32'h00000040, '0);
    rv_cnt = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      check_output("t6_err", err, (cyc >= 5));
      if (arb_if.arb_rvalid) rv_cnt++;
    end
    check_output("t6_rvalid_cnt", rv_cnt, 1);
    @(negedge clk);
    corrupt_idx = -1;
    pulse_reset();
`endif

    // Random traffic with back-pressure, gaps and stray read beats.
    @(negedge clk);
    ready_pct = 70;
    fixed_gap = -1;
    rand_data = 1'b1;
    allow_spurious = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      arb_if.arb_read  = ($urandom_range(0, 99) < 30);
      arb_if.arb_write = ($urandom_range(0, 99) < 20);
      arb_if.arb_addr  = $urandom;
      arb_if.arb_wdata = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      if (n == 1500) pulse_reset();
    end
    @(posedge clk);
    #1;
    arb_if.arb_read  = 1'b0;
    arb_if.arb_write = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
